// File: rtl/alarm_panel.sv
// Alarm controller FSM: arm/disarm by keypad code, exit/entry delays, timed siren and zone trip record.
// Latency: every input acts on the next rising edge; all outputs are registered or decoded from state.
// Backpressure: none; all inputs are single-cycle strobes or levels and are never stalled.
module alarm_panel #(
  parameter int                  N_ZONES     = 4,
  parameter logic [N_ZONES-1:0]  DELAY_MASK  = 4'b0001,
  parameter int                  EXIT_CYC    = 8,
  parameter int                  ENTRY_CYC   = 8,
  parameter int                  SIREN_CYC   = 16,
  parameter int                  CODE_W      = 8,
  parameter logic [CODE_W-1:0]   DISARM_CODE = 8'hA5,
  parameter int                  MAX_BAD     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_ZONES-1:0] zone_alarm,
  input  logic               arm_req,
  input  logic               code_valid,
  input  logic [CODE_W-1:0]  code_in,
  output logic               siren,
  output logic               armed,
  output logic               arm_fail,
  output logic [2:0]         state,
  output logic [N_ZONES-1:0] zone_latch
);

  localparam int MAX_CYC_A = (EXIT_CYC > ENTRY_CYC) ? EXIT_CYC : ENTRY_CYC;
  localparam int MAX_CYC   = (MAX_CYC_A > SIREN_CYC) ? MAX_CYC_A : SIREN_CYC;
  localparam int TMR_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int BAD_W     = $clog2(MAX_BAD + 1);

  localparam logic [TMR_W-1:0] EXIT_LOAD  = TMR_W'(EXIT_CYC - 1);
  localparam logic [TMR_W-1:0] ENTRY_LOAD = TMR_W'(ENTRY_CYC - 1);
  localparam logic [TMR_W-1:0] SIREN_LOAD = TMR_W'(SIREN_CYC - 1);
  // A bad code arriving while the count already sits here is the one that hits MAX_BAD.
  localparam logic [BAD_W-1:0] BAD_LAST   = BAD_W'(MAX_BAD - 1);
  localparam logic [BAD_W-1:0] BAD_CAP    = BAD_W'(MAX_BAD);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  state_t             r_state;
  logic [TMR_W-1:0]   r_timer;
  logic [BAD_W-1:0]   r_bad_cnt;
  logic [N_ZONES-1:0] r_zone_latch;
  logic               r_arm_fail;

  logic w_ok;
  logic w_bad;
  logic w_instant;
  logic w_delayed;

  assign w_ok      = code_valid && (code_in == DISARM_CODE);
  assign w_bad     = code_valid && !w_ok;
  assign w_instant = |(zone_alarm & ~DELAY_MASK);
  assign w_delayed = |(zone_alarm & DELAY_MASK);

  // Main controller: state, delay timer, bad-code count, zone record and arm-fail pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_DISARMED;
      r_timer      <= '0;
      r_bad_cnt    <= '0;
      r_zone_latch <= '0;
      r_arm_fail   <= 1'b0;
    end else begin
      r_arm_fail <= 1'b0;
      case (r_state)
        S_DISARMED: begin
          // Codes are meaningless here; arm_req always takes precedence.
          r_bad_cnt <= '0;
          if (arm_req) begin
            if (zone_alarm == '0) begin
              r_state      <= S_EXIT;
              r_timer      <= EXIT_LOAD;
              r_zone_latch <= '0;
            end else begin
              r_arm_fail <= 1'b1;
            end
          end
        end
        S_EXIT: begin
          // Zones are ignored so the occupant can walk out through a door zone.
          if (w_ok) begin
            r_state <= S_DISARMED;
            r_timer <= '0;
          end else if (r_timer == '0) begin
            r_state <= S_ARMED;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_ARMED: begin
          r_zone_latch <= r_zone_latch | zone_alarm;
          if (w_instant) begin
            r_state <= S_ALARM;
            r_timer <= SIREN_LOAD;
          end else if (w_delayed) begin
            r_state   <= S_ENTRY;
            r_timer   <= ENTRY_LOAD;
            r_bad_cnt <= '0;
          end
        end
        S_ENTRY: begin
          r_zone_latch <= r_zone_latch | zone_alarm;
          if (w_ok) begin
            r_state   <= S_DISARMED;
            r_timer   <= '0;
            r_bad_cnt <= '0;
          end else if (w_instant || (w_bad && (r_bad_cnt >= BAD_LAST)) || (r_timer == '0)) begin
            r_state <= S_ALARM;
            r_timer <= SIREN_LOAD;
          end else begin
            r_timer <= r_timer - 1'b1;
            if (w_bad && (r_bad_cnt != BAD_CAP)) begin
              r_bad_cnt <= r_bad_cnt + 1'b1;
            end
          end
        end
        S_ALARM: begin
          // On timeout re-arm keeping the record; a zone still high re-trips next cycle.
          r_zone_latch <= r_zone_latch | zone_alarm;
          if (w_ok) begin
            r_state   <= S_DISARMED;
            r_timer   <= '0;
            r_bad_cnt <= '0;
          end else if (r_timer == '0) begin
            r_state <= S_ARMED;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: begin
          r_state <= S_DISARMED;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign state      = r_state;
  assign siren      = (r_state == S_ALARM);
  assign armed      = (r_state == S_ARMED) || (r_state == S_ENTRY) || (r_state == S_ALARM);
  assign arm_fail   = r_arm_fail;
  assign zone_latch = r_zone_latch;

endmodule
